mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory stage of the 5-stage RISC-V pipeline. It consumes the Execute/Memory pipeline register outputs (ALU result, store data, destination register, PC+4, control). It performs load/store byte-lane alignment and sign extension against a req/ack data-memory bus, stalling the front of the pipeline while an access waits. It also contains the Memory/Writeback pipeline register feeding the writeback mux.

## Interface
Parameters:
- TIMEOUT, 16: max cycles in WAIT before an access is abandoned as a bus error (≥2).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- ALUResultM  in  32  effective address / ALU result
- WriteDataM  in  32  store data (rs2)
- RdM  in  5  destination register
- PCPlus4M  in  32  PC+4 of the instruction
- RegWriteM  in  1  instruction writes rd
- ResultSrcM  in  2  writeback select, passed through
- MemReadM  in  1  load
- MemWriteM  in  1  store
- Funct3M  in  3  access size/sign
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address, bits [1:0] = 0
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-positioned store data
- dmem_rdata  in  32  read data, valid with ack
- dmem_ack  in  1  access complete
- StallM  out  1  hold PC, IF/ID, ID/EX, EX/MEM
- BusErrW  out  1  registered: access timed out
- MisalignW  out  1  registered: misaligned access trapped
- ALUResultW, ReadDataW, PCPlus4W  out  32  MEM/WB values
- RdW  out  5; RegWriteW  out  1; ResultSrcW  out  2

## Operation
- Access = MemReadM | MemWriteM. MemWriteM has priority if both are set.
- Misaligned: half-word size with addr[0]=1, or word size with addr[1:0]≠0.
- Access sizes:
  - Funct3 000/100: byte.
  - 001/101: half.
  - 010: word.
  - Other values: treated as word.
- Byte enables:
  - Byte: be = 0001<<addr[1:0].
  - Half: be = 0011<<{addr[1],0}.
  - Word: be = 1111.
  - Loads drive the same be.
- Store data: wdata is the byte replicated ×4 for byte stores, the half replicated ×2 for half stores, WriteDataM for word stores.
- Load extraction: select the lane by addr[1:0]. Sign-extend for 000/001, zero-extend for 100/101.
- dmem_addr = {ALUResultM[31:2],2'b00}. Bus outputs are combinational from the M inputs, which upstream holds stable while StallM=1.
- FSM states:
  - IDLE: on a valid, non-trapped access, dmem_req=1. If dmem_ack is high the same cycle, the access completes and the FSM stays in IDLE. Otherwise StallM=1, the counter clears, and the FSM goes to WAIT.
  - WAIT: dmem_req=1, StallM=1, counter increments.
    - On dmem_ack: complete, StallM=0 that cycle, go to IDLE.
    - If the counter reaches TIMEOUT-1 without ack: abandon, StallM=0, BusErrW←1, RegWriteW←0, ReadDataW←0, go to IDLE.
- MEM/WB register:
  - Each cycle with StallM=0 it captures the M values, with ReadDataW taken from the extracted load data.
  - Each cycle with StallM=1 it captures a bubble: RegWriteW=0, RdW=0, BusErrW=0, MisalignW=0, other fields 0.
- Non-access instructions pass through with no bus activity and no stall.

## Timing
- Reset: all outputs 0 (dmem_req=0 while reset is high), state = IDLE, counter = 0.
- Reset during WAIT: the bus request drops immediately and no completion is registered.
- Zero-wait memory (ack in the request cycle): 1-cycle stage, no stall. Results appear on the W outputs after the next rising edge.
- N-wait memory: StallM is high for N cycles. W outputs update on the edge following the ack cycle.
- Ack arriving on the timeout cycle: ack wins, normal completion.
- dmem_ack while dmem_req=0: ignored.
- BusErrW and MisalignW are single-cycle pulses aligned with the faulting instruction's W slot.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - A misaligned access issues no bus request and causes no stall.
  - RegWriteW←0 and MisalignW←1 for that instruction.
- MEM_MISALIGN_TRAP_EN undefined:
  - Misalignment is not checked and MisalignW is tied to 0.
  - The access proceeds using the truncated word address and the lane offset derived from the low address bits. For half-word accesses, addr[0] is ignored.

## Test plan
- LW, addr 0x100, rdata 0xDEADBEEF, ack same cycle → StallM never 1; dmem_be=1111; next edge ReadDataW=0xDEADBEEF, RegWriteW=1.
- LB, addr 0x103, rdata 0x80FF_FF7F → be=1000; ReadDataW=0xFFFFFF80. Repeat as LBU → 0x00000080.
- SH, addr 0x202, WriteDataM 0x1234ABCD, ack after 3 cycles → StallM high 3 cycles; dmem_wdata=0xABCDABCD; be=1100; dmem_we=1; 3 bubbles then RegWriteW=0 slot.
- LW with no ack, TIMEOUT=16 → StallM high 15 cycles; then BusErrW=1 for one cycle, RegWriteW=0, ReadDataW=0.
- LW, addr 0x101 with MEM_MISALIGN_TRAP_EN → dmem_req stays 0; MisalignW=1, RegWriteW=0. Without the macro → addr 0x100 read, ReadDataW=rdata.
- reset asserted in WAIT cycle 2 → dmem_req=0 immediately; all W outputs 0; after release, a new LW completes normally.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory stage: load/store lane alignment, req/ack bus handshake with
// timeout, and the MEM/WB pipeline register feeding writeback.
// Ports: clk, reset (async, active-high); M-stage inputs (ALUResultM,
//   WriteDataM, RdM, PCPlus4M, RegWriteM, ResultSrcM, MemReadM, MemWriteM,
//   Funct3M); data bus (dmem_req/we/addr/be/wdata out, dmem_rdata/ack in);
//   StallM to the front end; registered W outputs incl. BusErrW, MisalignW.
// Optional: define MEM_MISALIGN_TRAP_EN to trap misaligned accesses.
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  RdM,
  input  logic [31:0] PCPlus4M,
  input  logic        RegWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        StallM,
  output logic        BusErrW,
  output logic        MisalignW,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W,
  output logic [4:0]  RdW,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 2);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic access, is_load, is_byte, is_half, sgn;
  logic trap, go;
  logic req, stall, done, abort;
  logic [3:0]  be;
  logic [31:0] wdata, load_data;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign access  = MemReadM | MemWriteM;
  assign is_load = MemReadM & ~MemWriteM;
  assign is_byte = Funct3M[1:0] == 2'b00;
  assign is_half = Funct3M[1:0] == 2'b01;
  assign sgn     = ~Funct3M[2];

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = is_half ? ALUResultM[0]
                  : (!is_byte && (ALUResultM[1:0] != 2'b00));
  assign trap = access & misalign;
`else
  assign trap = 1'b0;
`endif

  assign go = access & ~trap;

  // Half lanes ignore addr[0]; word accesses ignore both low bits.
  assign lane_b = dmem_rdata[{ALUResultM[1:0], 3'b000} +: 8];
  assign lane_h = dmem_rdata[{ALUResultM[1], 4'b0000} +: 16];

  always_comb begin
    be        = 4'b1111;
    wdata     = WriteDataM;
    load_data = dmem_rdata;
    unique case (1'b1)
      is_byte: begin
        be        = 4'b0001 << ALUResultM[1:0];
        wdata     = {4{WriteDataM[7:0]}};
        load_data = {{24{sgn & lane_b[7]}}, lane_b};
      end
      is_half: begin
        be        = 4'b0011 << {ALUResultM[1], 1'b0};
        wdata     = {2{WriteDataM[15:0]}};
        load_data = {{16{sgn & lane_h[15]}}, lane_h};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req     = 1'b0;
    stall   = 1'b0;
    done    = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          req = 1'b1;
          if (dmem_ack) begin
            done = 1'b1;
          end else begin
            stall   = 1'b1;
            cnt_d   = '0;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        req = 1'b1;
        if (dmem_ack) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == LAST) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus request and stall drop the instant reset rises.
  assign dmem_req   = req & ~reset;
  assign StallM     = stall & ~reset;
  assign dmem_we    = dmem_req & MemWriteM;
  assign dmem_addr  = {ALUResultM[31:2], 2'b00} & {32{~reset}};
  assign dmem_be    = be & {4{~reset}};
  assign dmem_wdata = wdata & {32{~reset}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset || stall) begin
      ALUResultW <= '0;
      ReadDataW  <= '0;
      PCPlus4W   <= '0;
      RdW        <= '0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= '0;
      BusErrW    <= 1'b0;
      MisalignW  <= 1'b0;
    end else begin
      ALUResultW <= ALUResultM;
      ReadDataW  <= (done & is_load) ? load_data : 32'h0;
      PCPlus4W   <= PCPlus4M;
      RdW        <= RdM;
      RegWriteW  <= RegWriteM & ~abort & ~trap;
      ResultSrcW <= ResultSrcM;
      BusErrW    <= abort;
      MisalignW  <= trap;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios plus random loads/stores
// checked against a behavioural byte-lane and timing model.
module tb_mem_access_stage;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        RegWriteM, MemReadM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        StallM, BusErrW, MisalignW;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  logic [4:0]  RdW;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;

  int nchk = 0;
  int npass = 0;

  mem_access_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM),
    .PCPlus4M(PCPlus4M), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .StallM(StallM), .BusErrW(BusErrW),
    .MisalignW(MisalignW), .ALUResultW(ALUResultW), .ReadDataW(ReadDataW),
    .PCPlus4W(PCPlus4W), .RdW(RdW), .RegWriteW(RegWriteW),
    .ResultSrcW(ResultSrcW)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic bit misaligned(input logic [2:0] f3, input logic [31:0] a);
    int s = size_of(f3);
    return (s > 1) && ((a % s) != 0);
  endfunction

  function automatic logic [31:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
    int s = size_of(f3);
    if (s == 1) return 32'd1 << (a % 4);
    if (s == 2) return 32'd3 << (a & 2);
    return 32'd15;
  endfunction

  function automatic logic [31:0] exp_wd(input logic [2:0] f3, input logic [31:0] d);
    int s = size_of(f3);
    if (s == 1) return (d & 32'hFF) * 32'h01010101;
    if (s == 2) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] exp_ld(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] r);
    int s = size_of(f3);
    logic [31:0] mask, v;
    int off;
    if (s == 4) return r;
    off  = (s == 2) ? (a & 2) : (a % 4);
    mask = (s == 2) ? 32'hFFFF : 32'hFF;
    v    = (r >> (8 * off)) & mask;
    if (f3[2] == 1'b0 && (v & ((mask >> 1) + 1)) != 0) v = v | ~mask;
    return v;
  endfunction

  // One instruction in M; wait_n = request-cycle index carrying ack (-1: never).
  task automatic run_op(input string nm, input logic rd_en, input logic wr_en,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rdat,
                        input int wait_n);
    logic [4:0]  rd   = 5'($urandom);
    logic [31:0] pc   = $urandom;
    logic [1:0]  rsrc = 2'($urandom);
    logic        regw = rd_en ? 1'b1 : 1'($urandom);
    bit acc  = rd_en | wr_en;
    bit ld   = rd_en & ~wr_en;
    bit trap = 0;
    bit go, berr;
    int nst, k;
`ifdef MEM_MISALIGN_TRAP_EN
    trap = acc && misaligned(f3, a);
`endif
    go   = acc && !trap;
    berr = go && (wait_n < 0 || wait_n > TIMEOUT - 1);
    nst  = !go ? 0 : (berr ? TIMEOUT - 1 : wait_n);
    ALUResultM = a; WriteDataM = wd; RdM = rd; PCPlus4M = pc;
    RegWriteM = regw; ResultSrcM = rsrc; MemReadM = rd_en;
    MemWriteM = wr_en; Funct3M = f3; dmem_rdata = rdat;
    k = 0;
    forever begin
      dmem_ack = go ? (k == wait_n) : 1'($urandom);
      @(negedge clk);
      chk({nm, " req"}, dmem_req, go);
      chk({nm, " stall"}, StallM, k < nst);
      if (go) begin
        chk({nm, " be"}, dmem_be, exp_be(f3, a));
        chk({nm, " we"}, dmem_we, wr_en);
        chk({nm, " addr"}, dmem_addr, a & ~32'd3);
        if (wr_en) chk({nm, " wdata"}, dmem_wdata, exp_wd(f3, wd));
      end
      @(posedge clk); #1;
      if (k >= nst) break;
      chk({nm, " bubble"}, {RegWriteW, RdW, BusErrW, MisalignW}, 8'h0);
      k++;
    end
    dmem_ack = 1'b0;
    chk({nm, " W regw"}, RegWriteW, regw & !berr & !trap);
    chk({nm, " W rd/src"}, {RdW, ResultSrcW}, {rd, rsrc});
    chk({nm, " W alu/pc"}, {ALUResultW, PCPlus4W}, {a, pc});
    chk({nm, " W rdata"}, ReadDataW,
        (ld && go && !berr) ? exp_ld(f3, a, rdat) : 32'h0);
    chk({nm, " W berr"}, BusErrW, berr);
    chk({nm, " W misal"}, MisalignW, trap);
  endtask

  initial begin
    reset = 1'b1;
    ALUResultM = 32'h100; WriteDataM = '0; RdM = 5'd1; PCPlus4M = '0;
    RegWriteM = 1'b1; ResultSrcM = '0; MemReadM = 1'b1; MemWriteM = 1'b0;
    Funct3M = 3'd2; dmem_rdata = '0; dmem_ack = 1'b0;
    #3;
    chk("reset req/stall", {dmem_req, StallM}, 2'b00);
    chk("reset W", {ALUResultW, ReadDataW, PCPlus4W, RdW, RegWriteW,
                    ResultSrcW, BusErrW, MisalignW}, '0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    run_op("lw0", 1, 0, 3'd2, 32'h100, 0, 32'hDEADBEEF, 0);
    run_op("lb", 1, 0, 3'd0, 32'h103, 0, 32'h80FFFF7F, 0);
    run_op("lbu", 1, 0, 3'd4, 32'h103, 0, 32'h80FFFF7F, 0);
    run_op("sh", 0, 1, 3'd1, 32'h202, 32'h1234ABCD, 0, 3);
    run_op("lwto", 1, 0, 3'd2, 32'h400, 0, 32'h55AA55AA, -1);
    run_op("lwedge", 1, 0, 3'd2, 32'h404, 0, 32'h12345678, TIMEOUT - 1);
    run_op("lwmis", 1, 0, 3'd2, 32'h101, 0, 32'hCAFEF00D, 0);
    run_op("lhmis", 1, 0, 3'd5, 32'h103, 0, 32'h8001CAFE, 1);
    run_op("alu", 0, 0, 3'd0, 32'h77, 0, 32'hFFFFFFFF, 0);

    // Reset while waiting on the bus.
    ALUResultM = 32'h300; MemReadM = 1'b1; MemWriteM = 1'b0;
    Funct3M = 3'd2; RegWriteM = 1'b1; dmem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 reset = 1'b1;
    #1;
    chk("rst-wait req/stall", {dmem_req, StallM}, 2'b00);
    chk("rst-wait W", {ALUResultW, ReadDataW, PCPlus4W, RdW, RegWriteW,
                       ResultSrcW, BusErrW, MisalignW}, '0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    run_op("lw-after-rst", 1, 0, 3'd2, 32'h300, 0, 32'h0BADC0DE, 1);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] f3s [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      int kind = $urandom_range(0, 2);
      int w = $urandom_range(0, 5);
      if (w == 5) w = ($urandom_range(0, 1) == 1) ? -1 : TIMEOUT - 1;
      run_op("rnd", kind == 0, kind == 1, f3s[$urandom_range(0, 4)],
             $urandom, $urandom, $urandom, w);
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
